// File: rtl/datapath_ctrl.sv
// datapath_ctrl: multi-cycle LEGv8-subset sequencer for dataPath_V2.
// Fetches, decodes and drives the per-cycle control word.
module datapath_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  output logic [31:0] instr_addr,
  output logic        instr_req,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic [4:0]  SA,
  output logic [4:0]  SB,
  output logic [4:0]  DA,
  output logic [4:0]  FS,
  output logic        C0,
  output logic [63:0] k,
  output logic        B_Sel,
  output logic        EN_B,
  output logic        EN_ALU,
  output logic        EN_ADDR_ALU,
  output logic        ram_cs,
  output logic        ram_write_en,
  output logic        ram_read_en,
  output logic [1:0]  ramOutsize,
  output logic        w_reg,
  output logic        retire,
  output logic        illegal
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, HALT
  } state_t;

  typedef struct packed {
    logic        bad;
    logic        mem;
    logic        ld;
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [4:0]  da;
    logic [4:0]  fs;
    logic        c0;
    logic        bsel;
    logic [63:0] k;
  } dec_t;

  localparam dec_t RST_DEC = '{
    bad: 1'b0, mem: 1'b0, ld: 1'b0,
    sa: 5'd31, sb: 5'd31, da: 5'd31,
    fs: 5'd0, c0: 1'b0, bsel: 1'b0,
    k: 64'd0
  };

  function automatic dec_t decode(input logic [31:0] i);
    dec_t        d;
    logic [10:0] op11;
    logic [9:0]  op10;
    logic [63:0] zimm;
    logic [63:0] simm;
    op11 = i[31:21];
    op10 = i[31:22];
    zimm = {52'd0, i[21:10]};
    simm = {{55{i[20]}}, i[20:12]};
    d    = '0;
    d.sa = i[9:5];
    d.sb = i[20:16];
    d.da = i[4:0];
    unique case (1'b1)
      op11 == 11'b10001011000: d.fs = 5'b01000;
      op11 == 11'b11001011000: begin
        d.fs = 5'b01001;
        d.c0 = 1'b1;
      end
      op11 == 11'b10001010000: d.fs = 5'b00000;
      op11 == 11'b10101010000: d.fs = 5'b01100;
      op10 == 10'b1001000100: begin
        d.fs   = 5'b01000;
        d.bsel = 1'b1;
        d.sb   = 5'd31;
        d.k    = zimm;
      end
      op10 == 10'b1101000100: begin
        d.fs   = 5'b01001;
        d.c0   = 1'b1;
        d.bsel = 1'b1;
        d.sb   = 5'd31;
        d.k    = zimm;
      end
      op10 == 10'b1001001000: begin
        d.fs   = 5'b00000;
        d.bsel = 1'b1;
        d.sb   = 5'd31;
        d.k    = zimm;
      end
      op10 == 10'b1011001000: begin
        d.fs   = 5'b01100;
        d.bsel = 1'b1;
        d.sb   = 5'd31;
        d.k    = zimm;
      end
      op11 == 11'b11111000010: begin
        d.fs   = 5'b01000;
        d.bsel = 1'b1;
        d.k    = simm;
        d.mem  = 1'b1;
        d.ld   = 1'b1;
        d.sb   = 5'd31;
      end
      op11 == 11'b11111000000: begin
        d.fs   = 5'b01000;
        d.bsel = 1'b1;
        d.k    = simm;
        d.mem  = 1'b1;
        d.sb   = i[4:0];
        d.da   = 5'd31;
      end
      default: d.bad = 1'b1;
    endcase
    return d;
  endfunction

  state_t state;
  dec_t   cur;
  dec_t   fd;

  always_comb fd = decode(instr);

  assign SA         = cur.sa;
  assign SB         = cur.sb;
  assign DA         = cur.da;
  assign FS         = cur.fs;
  assign C0         = cur.c0;
  assign k          = cur.k;
  assign B_Sel      = cur.bsel;
  assign ramOutsize = 2'b11;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cur          <= RST_DEC;
      instr_addr   <= '0;
      instr_req    <= 1'b0;
      EN_B         <= 1'b0;
      EN_ALU       <= 1'b0;
      EN_ADDR_ALU  <= 1'b0;
      ram_cs       <= 1'b0;
      ram_write_en <= 1'b0;
      ram_read_en  <= 1'b0;
      w_reg        <= 1'b0;
      retire       <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      EN_B         <= 1'b0;
      EN_ALU       <= 1'b0;
      EN_ADDR_ALU  <= 1'b0;
      ram_cs       <= 1'b0;
      ram_write_en <= 1'b0;
      ram_read_en  <= 1'b0;
      w_reg        <= 1'b0;
      retire       <= 1'b0;
      unique case (state)
        IDLE: if (run) begin
          state     <= FETCH;
          instr_req <= 1'b1;
        end
        FETCH: if (instr_valid) begin
          cur       <= fd;
          instr_req <= 1'b0;
          state     <= DECODE;
        end
        DECODE: if (cur.bad) begin
          state   <= HALT;
          illegal <= 1'b1;
        end else if (cur.mem) begin
          state       <= EXEC;
          EN_ADDR_ALU <= 1'b1;
          ram_cs      <= 1'b1;
        end else begin
          state      <= EXEC;
          EN_ALU     <= 1'b1;
          w_reg      <= 1'b1;
          retire     <= 1'b1;
          instr_addr <= instr_addr + 32'd4;
        end
        EXEC: if (cur.mem) begin
          state        <= MEM;
          EN_ADDR_ALU  <= 1'b1;
          ram_cs       <= 1'b1;
          ram_read_en  <= cur.ld;
          w_reg        <= cur.ld;
          EN_B         <= !cur.ld;
          ram_write_en <= !cur.ld;
          retire       <= 1'b1;
          instr_addr   <= instr_addr + 32'd4;
        end else begin
          state     <= run ? FETCH : IDLE;
          instr_req <= run;
        end
        MEM: begin
          state     <= run ? FETCH : IDLE;
          instr_req <= run;
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl: scoreboard bench for datapath_ctrl.
// Expected control words are queued at issue and checked at retire.
module tb_datapath_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [31:0] instr_addr;
  logic        instr_req;
  logic        instr_valid;
  logic [31:0] instr;
  logic [4:0]  SA, SB, DA, FS;
  logic        C0;
  logic [63:0] k;
  logic        B_Sel, EN_B, EN_ALU, EN_ADDR_ALU;
  logic        ram_cs, ram_write_en, ram_read_en;
  logic [1:0]  ramOutsize;
  logic        w_reg, retire, illegal;

  datapath_ctrl dut (
    .clock(clk), .reset(rst_n), .run(run),
    .instr_addr(instr_addr), .instr_req(instr_req),
    .instr_valid(instr_valid), .instr(instr),
    .SA(SA), .SB(SB), .DA(DA), .FS(FS), .C0(C0),
    .k(k), .B_Sel(B_Sel), .EN_B(EN_B), .EN_ALU(EN_ALU),
    .EN_ADDR_ALU(EN_ADDR_ALU), .ram_cs(ram_cs),
    .ram_write_en(ram_write_en), .ram_read_en(ram_read_en),
    .ramOutsize(ramOutsize), .w_reg(w_reg),
    .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [9:0]  OP_ANDI = 10'b1001001000;
  localparam logic [9:0]  OP_ORRI = 10'b1011001000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  typedef struct {
    logic [4:0]  sa, sb, da, fs;
    logic        c0, bsel, sb_v, da_v, mem, ld;
    logic [63:0] k;
    logic [31:0] pc;
  } exp_t;

  exp_t        q[$];
  exp_t        last;
  logic [31:0] exp_pc;
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          acc_cyc = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_r(
    input logic [10:0] op, input logic [4:0] rm,
    input logic [4:0] rn, input logic [4:0] rd);
    return {op, rm, 6'd0, rn, rd};
  endfunction

  function automatic logic [31:0] enc_i(
    input logic [9:0] op, input logic [11:0] imm,
    input logic [4:0] rn, input logic [4:0] rd);
    return {op, imm, rn, rd};
  endfunction

  function automatic logic [31:0] enc_d(
    input logic [10:0] op, input logic [8:0] dt,
    input logic [4:0] rn, input logic [4:0] rt);
    return {op, dt, 2'b00, rn, rt};
  endfunction

  function automatic exp_t er(
    input logic [4:0] fs, input logic c0,
    input logic [4:0] rd, input logic [4:0] rn,
    input logic [4:0] rm);
    exp_t e;
    e.sa = rn; e.sb = rm; e.da = rd;
    e.fs = fs; e.c0 = c0; e.bsel = 1'b0;
    e.k = '0; e.sb_v = 1'b1; e.da_v = 1'b1;
    e.mem = 1'b0; e.ld = 1'b0; e.pc = '0;
    return e;
  endfunction

  function automatic exp_t ei(
    input logic [4:0] fs, input logic c0,
    input logic [4:0] rd, input logic [4:0] rn,
    input logic [63:0] kv);
    exp_t e;
    e.sa = rn; e.sb = '0; e.da = rd;
    e.fs = fs; e.c0 = c0; e.bsel = 1'b1;
    e.k = kv; e.sb_v = 1'b0; e.da_v = 1'b1;
    e.mem = 1'b0; e.ld = 1'b0; e.pc = '0;
    return e;
  endfunction

  function automatic exp_t ed(
    input logic ld, input logic [4:0] rt,
    input logic [4:0] rn, input logic [63:0] kv);
    exp_t e;
    e.sa = rn; e.sb = rt; e.da = rt;
    e.fs = 5'b01000; e.c0 = 1'b0; e.bsel = 1'b1;
    e.k = kv; e.sb_v = !ld; e.da_v = ld;
    e.mem = 1'b1; e.ld = ld; e.pc = '0;
    return e;
  endfunction

  function automatic logic [7:0] en_vec();
    return {EN_B, EN_ALU, EN_ADDR_ALU, ram_cs,
            ram_write_en, ram_read_en, w_reg, retire};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (rst_n) begin
    check("bus", 64'(int'(EN_B) + int'(EN_ALU)
          + int'(ram_read_en) <= 1), 64'd1);
    if (instr_req && instr_valid) acc_cyc = cyc;
    if (retire) begin
      if (q.size() == 0) begin
        check("sb_empty", 64'd0, 64'd1);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("pc", 64'(instr_addr), 64'(e.pc));
        check("sa", 64'(SA), 64'(e.sa));
        if (e.sb_v) check("sb", 64'(SB), 64'(e.sb));
        if (e.da_v) check("da", 64'(DA), 64'(e.da));
        check("fs", 64'(FS), 64'(e.fs));
        check("c0", 64'(C0), 64'(e.c0));
        check("bsel", 64'(B_Sel), 64'(e.bsel));
        if (e.bsel) check("k", k, e.k);
        check("wreg", 64'(w_reg), 64'(!e.mem || e.ld));
        check("en_alu", 64'(EN_ALU), 64'(!e.mem));
        check("rd_en", 64'(ram_read_en), 64'(e.mem && e.ld));
        check("en_b", 64'(EN_B), 64'(e.mem && !e.ld));
        check("wr_en", 64'(ram_write_en), 64'(e.mem && !e.ld));
        check("addr_alu", 64'(EN_ADDR_ALU), 64'(e.mem));
        check("cs", 64'(ram_cs), 64'(e.mem));
        check("osize", 64'(ramOutsize), 64'd3);
        check("lat", 64'(cyc - acc_cyc), e.mem ? 64'd3 : 64'd2);
      end
    end
  end

  task automatic wait_req();
    int n = 0;
    while (!instr_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req", 64'(instr_req), 64'd1);
  endtask

  task automatic issue(input logic [31:0] w, input exp_t e);
    wait_req();
    exp_pc = exp_pc + 32'd4;
    e.pc = exp_pc;
    q.push_back(e);
    last = e;
    instr = w;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    instr = $urandom();
    check("dec_sa", 64'(SA), 64'(e.sa));
    if (e.sb_v) check("dec_sb", 64'(SB), 64'(e.sb));
    if (e.da_v) check("dec_da", 64'(DA), 64'(e.da));
    check("dec_fs", 64'(FS), 64'(e.fs));
    check("dec_c0", 64'(C0), 64'(e.c0));
    check("dec_bsel", 64'(B_Sel), 64'(e.bsel));
    if (e.bsel) check("dec_k", k, e.k);
    check("dec_en", 64'({en_vec(), instr_req}), 64'd0);
  endtask

  task automatic exec_chk();
    @(negedge clk);
    check("ex_addr", 64'(EN_ADDR_ALU), 64'd1);
    check("ex_cs", 64'(ram_cs), 64'd1);
    check("ex_rest", 64'({EN_B, EN_ALU, ram_write_en,
          ram_read_en, w_reg, retire}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    run = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    exp_pc = '0;
    repeat (2) @(negedge clk);
    check("rst_pc", 64'(instr_addr), 64'd0);
    check("rst_sa", 64'(SA), 64'd31);
    check("rst_sb", 64'(SB), 64'd31);
    check("rst_da", 64'(DA), 64'd31);
    check("rst_fs", 64'(FS), 64'd0);
    check("rst_c0", 64'(C0), 64'd0);
    check("rst_k", k, 64'd0);
    check("rst_bsel", 64'(B_Sel), 64'd0);
    check("rst_osize", 64'(ramOutsize), 64'd3);
    check("rst_en", 64'({en_vec(), instr_req, illegal}), 64'd0);
    rst_n = 1'b1;
    run = 1'b1;

    issue(enc_i(OP_ORRI, 12'd10, 5'd31, 5'd0),
          ei(5'b01100, 1'b0, 5'd0, 5'd31, 64'd10));
    issue(enc_r(OP_SUB, 5'd0, 5'd1, 5'd3),
          er(5'b01001, 1'b1, 5'd3, 5'd1, 5'd0));
    issue(enc_i(OP_ADDI, 12'hFFF, 5'd2, 5'd5),
          ei(5'b01000, 1'b0, 5'd5, 5'd2, 64'd4095));
    issue(enc_r(OP_AND, 5'd8, 5'd7, 5'd6),
          er(5'b00000, 1'b0, 5'd6, 5'd7, 5'd8));
    issue(enc_i(OP_SUBI, 12'd1, 5'd10, 5'd9),
          ei(5'b01001, 1'b1, 5'd9, 5'd10, 64'd1));
    issue(enc_d(OP_STUR, 9'h1F8, 5'd31, 5'd1),
          ed(1'b0, 5'd1, 5'd31, 64'hFFFF_FFFF_FFFF_FFF8));
    exec_chk();
    issue(enc_d(OP_LDUR, 9'd16, 5'd2, 5'd4),
          ed(1'b1, 5'd4, 5'd2, 64'd16));
    exec_chk();
    issue(enc_d(OP_LDUR, 9'd255, 5'd3, 5'd7),
          ed(1'b1, 5'd7, 5'd3, 64'd255));
    issue(enc_d(OP_STUR, 9'h100, 5'd9, 5'd8),
          ed(1'b0, 5'd8, 5'd9, 64'hFFFF_FFFF_FFFF_FF00));
    issue(enc_r(OP_ORR, 5'd12, 5'd11, 5'd10),
          er(5'b01100, 1'b0, 5'd10, 5'd11, 5'd12));
    issue(enc_i(OP_ANDI, 12'hF0F, 5'd14, 5'd13),
          ei(5'b00000, 1'b0, 5'd13, 5'd14, 64'hF0F));
    issue(enc_r(OP_ADD, 5'd17, 5'd16, 5'd15),
          er(5'b01000, 1'b0, 5'd15, 5'd16, 5'd17));

    issue(enc_r(OP_ADD, 5'd3, 5'd2, 5'd1),
          er(5'b01000, 1'b0, 5'd1, 5'd2, 5'd3));
    run = 1'b0;
    @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      check("idle_req", 64'(instr_req), 64'd0);
    end
    run = 1'b1;

    wait_req();
    repeat (5) begin
      @(negedge clk);
      check("stall_req", 64'(instr_req), 64'd1);
      check("stall_pc", 64'(instr_addr), 64'(exp_pc));
      check("stall_fs", 64'(FS), 64'(last.fs));
      check("stall_sa", 64'(SA), 64'(last.sa));
      check("stall_en", 64'(en_vec()), 64'd0);
    end

    issue(enc_d(OP_LDUR, 9'd16, 5'd2, 5'd4),
          ed(1'b1, 5'd4, 5'd2, 64'd16));
    exec_chk();
    @(negedge clk);
    check("mem_rd", 64'(ram_read_en), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_rd", 64'(ram_read_en), 64'd0);
    check("arst_en", 64'(en_vec()), 64'd0);
    check("arst_pc", 64'(instr_addr), 64'd0);
    exp_pc = '0;
    @(negedge clk);
    rst_n = 1'b1;

    issue(enc_r(OP_ADD, 5'd22, 5'd21, 5'd20),
          er(5'b01000, 1'b0, 5'd20, 5'd21, 5'd22));
    wait_req();
    instr = 32'h0000_0000;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("halt_ill", 64'(illegal), 64'd1);
      check("halt_en", 64'({en_vec(), instr_req}), 64'd0);
    end
    rst_n = 1'b0;
    #1;
    check("ill_rst", 64'(illegal), 64'd0);
    check("ill_pc", 64'(instr_addr), 64'd0);
    check("sb_left", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
